// File: rtl/ring_arb_pkg.sv
// Shared types and constants for the ring token arbiter.
package ring_arb_pkg;

  // Arbiter FSM: IDLE (no owner, looking for a request) or OWNED (grant held).
  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  localparam int DEF_N        = 4;
  localparam int DEF_MAX_HOLD = 8;

  // Hold counter width: enough for 0..MAX_HOLD, never narrower than one bit.
  function automatic int hold_cnt_w(input int max_hold);
    int w;
    w = $clog2(max_hold + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ring_priority_pick.sv
// Combinational round-robin pick: first set Req bit at or above the token
// position, wrapping from N-1 to 0. Rotates Req so the token sits at bit 0,
// isolates the lowest set bit, then rotates the result back.
module ring_priority_pick
  import ring_arb_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic [N-1:0] Req,
  input  logic [N-1:0] Token,
  output logic [N-1:0] Pick,
  output logic         Any
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] tok_idx;
  logic [N-1:0]  rot;
  logic [N-1:0]  lsb;

  // Rotate/mask/priority-encode relative to the token position.
  always_comb begin
    tok_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (Token[i]) tok_idx = IW'(i);
    end
    rot  = N'({Req, Req} >> tok_idx);
    lsb  = rot & (~rot + N'(1));
    Pick = N'(({lsb, lsb} << tok_idx) >> N);
    Any  = |Req;
  end

endmodule

// File: rtl/ring_token_arbiter.sv
// Round-robin arbiter with a rotating one-hot priority token.
// Handshake: a requester raises Req[i] and keeps it high while it wants the
// resource; once Grant[i] is seen it may use the resource until it drops
// Req[i] or pulses Done. The arbiter may also withdraw the grant after
// MAX_HOLD cycles (Expired pulses). Each release is followed by one idle
// cycle before the next grant, and the token moves past the last owner.
module ring_token_arbiter
  import ring_arb_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic [N-1:0]         Req,
  input  logic                 Done,
  output logic [N-1:0]         Grant,
  output logic [$clog2(N)-1:0] GrantIdx,
  output logic                 Busy,
  output logic                 Expired,
  output state_t               DbgState
);

  localparam int IW = $clog2(N);
  localparam int HW = hold_cnt_w(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t        state;
  logic [N-1:0]  token;
  logic [HW-1:0] hold_cnt;

  logic [N-1:0]  pick;
  logic          pick_any;
  logic [IW-1:0] pick_idx;

  ring_priority_pick #(.N(N)) u_pick (
    .Req   (Req),
    .Token (token),
    .Pick  (pick),
    .Any   (pick_any)
  );

  // Binary index of the one-hot pick.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (pick[i]) pick_idx = IW'(i);
    end
  end

  assign DbgState = state;

  // Arbiter FSM with registered outputs; reset wins over everything.
  always_ff @(posedge Clock) begin
    if (Resetn) begin
      state    <= IDLE;
      token    <= N'(1);
      hold_cnt <= '0;
      Grant    <= '0;
      GrantIdx <= '0;
      Busy     <= 1'b0;
      Expired  <= 1'b0;
    end else begin
      Expired <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            Grant    <= pick;
            GrantIdx <= pick_idx;
            Busy     <= 1'b1;
            hold_cnt <= '0;
            state    <= OWNED;
          end
        end
        OWNED: begin
          if (!Req[GrantIdx] || Done ||
              ((MAX_HOLD != 0) && (hold_cnt == HOLD_LAST))) begin
            // Done/drop take precedence, so Expired only on a pure timeout.
            Expired <= Req[GrantIdx] && !Done;
            Grant   <= '0;
            Busy    <= 1'b0;
            token   <= {Grant[N-2:0], Grant[N-1]};
            state   <= IDLE;
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ring_token_arbiter.md
Name: ring_token_arbiter

Overview:
Round-robin controller that shares one resource among N requesters. It uses a rotating one-hot priority token, the same ring-shift principle as our 4-bit ring counter. The block issues a one-hot grant, holds it until the owner releases it or a hold limit expires, then advances the token past the last owner. It sits between the requester blocks and the shared datapath, for example a shared register or a display digit driver.

Parameters:
N, 4, number of requesters; must be at least 2.
MAX_HOLD, 8, maximum cycles a grant may be held; 0 disables the limit.

Ports:
Clock  input  1  system clock; all logic on posedge.
Resetn  input  1  synchronous, active-high reset; despite the name, 1 = reset.
Req  input  N  request vector; bit i set means requester i wants the resource.
Done  input  1  release strobe from the current owner; ignored when no grant is active.
Grant  output  N  registered one-hot grant, or all zeros.
GrantIdx  output  $clog2(N)  binary index of the current owner; valid only while Busy=1.
Busy  output  1  high while a grant is active.
Expired  output  1  one-cycle pulse when a grant is forcibly ended by MAX_HOLD.

Behaviour:
- Reset (sampled on posedge while Resetn=1) sets: Grant=0, GrantIdx=0, Busy=0, Expired=0, state=IDLE, hold counter=0, internal one-hot token=1 (requester 0 has highest priority).
- Reset dominates every other input, including mid-grant. Grant drops at the reset edge and Expired does not pulse.
- States: IDLE and OWNED.
- IDLE:
  - If Req≠0, pick the first set Req bit scanning from the token position upward, wrapping from bit N-1 to bit 0.
  - At the next edge: Grant=that bit, GrantIdx=its index, Busy=1, hold counter=0, go to OWNED.
  - Latency from Req to Grant is one cycle.
  - If Req=0, stay in IDLE with outputs at zero.
- OWNED: each cycle, evaluate the release conditions in this priority order:
  1. Req[GrantIdx]=0: release.
  2. Done=1: release.
  3. MAX_HOLD≠0 and hold counter = MAX_HOLD-1: release and pulse Expired for one cycle.
  4. Otherwise: hold counter+1, Grant unchanged.
- Simultaneous events: if Done and the timeout coincide, the release counts as Done and Expired stays 0.
- Release edge:
  - Grant=0, Busy=0, go to IDLE.
  - Token = Grant rotated left by one, with bit N-1 wrapping to bit 0.
  - GrantIdx keeps its last value.
- With MAX_HOLD≠0, Grant is high for at most MAX_HOLD consecutive cycles.
- One mandatory idle bubble cycle separates consecutive grants; there is no direct handoff.
- Changes to Req from non-owners during OWNED have no effect.
- Grant is never multi-hot and is never non-zero while Busy=0.
- Hold counter width is $clog2(MAX_HOLD+1), minimum 1 bit; it never wraps.
- Fairness: with all requesters continuously active, every requester receives a grant within N grants.

Decomposition:
- Package ring_arb_pkg holds: the state encoding (IDLE, OWNED), default N and MAX_HOLD constants, and a function for hold-counter width.
- Sub-module ring_priority_pick: purely combinational. Inputs are Req and the one-hot token. Outputs are a one-hot pick and an any-request flag, computed with the rotate/mask/priority-encode method.
- The top level holds the state register, token register, hold counter and output registers.

Test Plan:
All scenarios use N=4 and MAX_HOLD=8.
1. Reset: hold Req=1111 during 3 reset cycles → Grant=0000 and Busy=0 throughout. Release Resetn → Grant=0001 and GrantIdx=0 one edge later.
2. Rotation: hold Req=1111 and pulse Done on the 2nd cycle of each grant → Grant sequence is 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001.
3. Skip and wrap: after requester 0 releases (token=0010), apply Req=1001 → Grant=1000 next. After its Done → Grant=0001, because the scan wraps past empty bits.
4. Timeout: hold Req=0100 with Done=0 → Grant=0100 for exactly 8 cycles, then Expired=1 for 1 cycle with Grant=0000. After the bubble cycle, Grant=0100 again.
5. Request drop and coincidence:
   - Owner's Req falls on cycle 3 → Grant=0000 next edge, Expired=0, token advances.
   - Done asserted on hold cycle 7 (the timeout cycle) → release with Expired=0.
6. Reset mid-grant: assert Resetn while Grant=0100 → Grant=0000, Busy=0 and Expired=0 at that edge. After reset with Req=0110 → Grant=0010, because the token has returned to requester 0.
